// File: rtl/serial_flow_driver.sv
// Transmit side of the two-line serial-flow interface: streams two operands LSB-first
// and reassembles the serial result (plus final overflow) returned by the downstream FSM.
module serial_flow_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             line1,
  output logic             line2,
  input  logic             outp,
  input  logic             overflw,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] tx_a;
  logic [WIDTH-1:0] tx_b;
  logic [WIDTH-1:0] rx;
  logic [CNT_W-1:0] cnt;

  logic             load;
  logic             shift;
  logic             last_shift;
  logic             finish;
  logic             sample;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    shift      = 1'b0;
    last_shift = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == LAST_BIT) begin
          last_shift = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The FSM's registered output lags the lines by one cycle, so the first
  // returned bit appears only at the end of the second SHIFT cycle.
  assign sample = shift && (cnt != '0);

  // Bit 0 is put on the lines by the load edge itself so that it is visible
  // for the whole first SHIFT cycle; later bits come from the tx registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_a    <= '0;
      tx_b    <= '0;
      rx      <= '0;
      cnt     <= '0;
      line1   <= 1'b0;
      line2   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      res_ovf <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        tx_a  <= op_a >> 1;
        tx_b  <= op_b >> 1;
        line1 <= op_a[0];
        line2 <= op_b[0];
        rx    <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (shift) begin
        if (last_shift) begin
          line1 <= 1'b0;
          line2 <= 1'b0;
        end else begin
          line1 <= tx_a[0];
          line2 <= tx_b[0];
          tx_a  <= tx_a >> 1;
          tx_b  <= tx_b >> 1;
        end
        cnt <= cnt + CNT_W'(1);
        if (sample) begin
          rx <= {outp, rx[WIDTH-1:1]};
        end
      end else if (finish) begin
        result  <= {outp, rx[WIDTH-1:1]};
        res_ovf <= overflw;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_flow_driver.sv
// Directed bench for serial_flow_driver, with a serial-adder / identity model
// standing in for the downstream FSM.
module tb_serial_flow_driver;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             line1;
  logic             line2;
  logic             outp;
  logic             overflw;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             res_ovf;

  logic             carry;
  logic             model_id;

  int n_checks = 0;
  int n_pass   = 0;

  serial_flow_driver #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .line1   (line1),
    .line2   (line2),
    .outp    (outp),
    .overflw (overflw),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .res_ovf (res_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream FSM model: registered serial adder, or identity when model_id=1.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      outp  <= 1'b0;
      carry <= 1'b0;
    end else if (model_id) begin
      outp  <= line1;
      carry <= 1'b0;
    end else begin
      outp  <= line1 ^ line2 ^ carry;
      carry <= (line1 & line2) | (line1 & carry) | (line2 & carry);
    end
  end
  assign overflw = carry;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Starts a transaction now and returns in its done cycle.
  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic exp_ovf, input logic inject);
    logic [7:0] la;
    logic [7:0] lb;
    logic [1:0] drain_lines;
    int         busy_cnt;
    int         early_done;
    la = '0; lb = '0; drain_lines = '0; busy_cnt = 0; early_done = 0;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick;
    for (int c = 0; c <= WIDTH; c++) begin
      if (c < WIDTH) begin
        la = {line1, la[7:1]};
        lb = {line2, lb[7:1]};
      end else begin
        drain_lines = {line1, line2};
      end
      busy_cnt   += int'(busy);
      early_done += int'(done);
      start = inject && (c == 3);
      op_a  = inject ? 8'h77 : ~a;
      op_b  = inject ? 8'h11 : ~b;
      tick;
    end
    start = 1'b0;
    check_val({tag, "_line1_seq"}, 32'(la), 32'(a));
    check_val({tag, "_line2_seq"}, 32'(lb), 32'(b));
    check_val({tag, "_drain_lines"}, 32'(drain_lines), 32'd0);
    check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
    check_val({tag, "_early_done"}, 32'(early_done), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_val({tag, "_result"}, 32'(result), 32'(exp_res));
    check_val({tag, "_res_ovf"}, 32'(res_ovf), 32'(exp_ovf));
  endtask

  task automatic post_done(input string tag, input logic [7:0] exp_res, input logic exp_ovf);
    tick;
    check_val({tag, "_done_fall"}, 32'(done), 32'd0);
    check_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check_val({tag, "_result_hold"}, 32'(result), 32'(exp_res));
    check_val({tag, "_ovf_hold"}, 32'(res_ovf), 32'(exp_ovf));
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    reset    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    model_id = 1'b0;
    repeat (2) tick;
    check_val("rst_line1", 32'(line1), 32'd0);
    check_val("rst_line2", 32'(line2), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_res_ovf", 32'(res_ovf), 32'd0);
    reset = 1'b1;
    repeat (2) tick;

    run_txn("t1", 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    post_done("t1", 8'h08, 1'b0);
    tick;

    // Overflow, then a back-to-back start issued in its done cycle.
    run_txn("t2", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_txn("t3", 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    post_done("t3", 8'h30, 1'b0);
    tick;

    run_txn("t4", 8'h21, 8'h12, 8'h33, 1'b0, 1'b1);
    post_done("t4", 8'h33, 1'b0);
    done_cnt = 0;
    busy_cnt = 0;
    repeat (12) begin
      tick;
      done_cnt += int'(done);
      busy_cnt += int'(busy);
    end
    check_val("t4_single_done", 32'(done_cnt), 32'd0);
    check_val("t4_no_restart", 32'(busy_cnt), 32'd0);

    // Reset while bit 4 is on the lines.
    start = 1'b1;
    op_a  = 8'hF0;
    op_b  = 8'h0F;
    tick;
    start = 1'b0;
    repeat (4) tick;
    check_val("t5_line1_bit4", 32'(line1), 32'd1);
    check_val("t5_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_val("t5_rst_line1", 32'(line1), 32'd0);
    check_val("t5_rst_line2", 32'(line2), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_done", 32'(done), 32'd0);
    check_val("t5_rst_result", 32'(result), 32'd0);
    repeat (2) tick;
    reset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (12) begin
      tick;
      done_cnt += int'(done);
      busy_cnt += int'(busy);
    end
    check_val("t5_no_done", 32'(done_cnt), 32'd0);
    check_val("t5_busy_low", 32'(busy_cnt), 32'd0);
    check_val("t5_result_cleared", 32'(result), 32'd0);

    model_id = 1'b1;
    tick;
    run_txn("t6a", 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);
    post_done("t6a", 8'hA5, 1'b0);
    run_txn("t6b", 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0);
    post_done("t6b", 8'h5A, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_flow_driver.md
# serial_flow_driver

Transmit side of the two-line serial-flow interface: accepts two WIDTH-bit operands, drives them LSB-first on `line1`/`line2`, and collects the result from the downstream serial-flow FSM. That FSM returns its serial result on `outp` and `overflw`. This block reassembles the returned `outp` stream into a parallel word and latches the final `overflw`. It sits between a register-mapped host and the serial-flow FSM.

## Interface

**Parameters**
- `WIDTH`, default 8: operand/result width in bits, legal range 2..32.

**Ports**
- `clock`  in  1  single clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; `op_a`/`op_b` are sampled on the same edge.
- `op_a`  in  WIDTH  operand streamed on `line1`.
- `op_b`  in  WIDTH  operand streamed on `line2`.
- `line1`  out  1  serial bit of `op_a`, registered.
- `line2`  out  1  serial bit of `op_b`, registered.
- `outp`  in  1  serial result bit from the FSM; registered there, 1-cycle latency.
- `overflw`  in  1  overflow flag from the FSM.
- `busy`  out  1  transaction in flight.
- `done`  out  1  one-cycle pulse; `result`/`res_ovf` are valid from this cycle.
- `result`  out  WIDTH  reassembled result, LSB = first returned bit.
- `res_ovf`  out  1  `overflw` sampled with the last result bit.

## Operation

**Reset** (`reset`=0, asynchronous):
- State goes to IDLE.
- `line1`, `line2`, `busy`, `done` and `res_ovf` are 0; `result` is 0.
- Shift registers and bit counter are cleared.
- Asserting reset mid-transaction aborts it: no `done` and no partial `result` update.

**IDLE**
- `line1` = `line2` = 0; `busy` = 0.
- `start`=1 loads `op_a`/`op_b` into tx shift registers and the counter into 0, then moves to SHIFT.

**SHIFT** (WIDTH cycles)
- Each cycle drives tx bit i on `line1`/`line2`, then shifts the tx registers right.
- From the second SHIFT cycle onward, each edge samples `outp` into the rx shift register.
- The rx register shifts in at the MSB and shifts right, so the first returned bit ends up in `result[0]`.

**DRAIN** (1 cycle)
- `line1` = `line2` = 0.
- The edge at the end of DRAIN samples the final `outp` (bit WIDTH-1) and `overflw`.
- On that edge: `result` ← rx register, `res_ovf` ← `overflw`, `done` ← 1, state → IDLE.

**Holding and acceptance rules**
- `result` and `res_ovf` hold their values until the next `done`. They are not cleared on `start`.
- `start` while `busy`=1 is ignored; operands are not resampled.
- `start` in the cycle `done`=1 (`busy`=0) is accepted, giving back-to-back transactions.
- `op_a`/`op_b` may change freely after the sampling edge.

**Width and counter rules**
- No arithmetic is performed here; `result` is exactly the received bit sequence.
- The counter is ceil(log2(WIDTH+1)) bits and never wraps within a transaction.

## Timing

Let `start` be sampled at edge k.
- `busy` = 1 from edge k through edge k+WIDTH+1, i.e. WIDTH+1 cycles.
- Bit i (i = 0..WIDTH-1) is on `line1`/`line2` from edge k+i to edge k+i+1.
- `outp` for bit i is sampled at edge k+i+2.
- `done` rises at edge k+WIDTH+1 and is high for exactly one cycle; `busy` falls at the same edge.
- `res_ovf` is `overflw` as sampled at edge k+WIDTH+1.
- Start-to-done latency is WIDTH+1 cycles. Maximum throughput is one transaction per WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

The bench drives `outp`/`overflw` from a serial-adder model with 1-cycle registered output. WIDTH = 8.

1. **Basic add.** Reset low for 2 cycles, then high. `start` with `op_a`=0x05, `op_b`=0x03.
   - `line1` = 1,0,1,0,0,0,0,0 and `line2` = 1,1,0,0,0,0,0,0 on consecutive cycles.
   - `done` 9 cycles after `start`, with `result`=0x08 and `res_ovf`=0.
2. **Overflow.** `op_a`=0xFF, `op_b`=0x01; the model raises `overflw` with the last bit.
   - `result`=0x00, `res_ovf`=1, `busy` high for exactly 9 cycles.
3. **Back-to-back.** Pulse `start` (0x10 + 0x20) in the `done` cycle of a prior transaction.
   - Accepted with no idle cycle between transactions; second `result`=0x30.
4. **Start while busy.** Pulse `start` with different operands 3 cycles into a transaction.
   - Ignored; the line streams and `result` of the original transaction are unchanged, and exactly one `done` occurs.
5. **Reset mid-transaction.** Assert `reset`=0 at SHIFT bit 4.
   - All outputs go to 0 immediately, with no `done`.
   - After release, `busy`=0 until the next `start`; prior `result` is cleared to 0.
6. **Pattern sweep.** `op_b`=0 with `op_a`=0xA5, then 0x5A, and an identity model (`outp`=`line1` delayed by 1).
   - `result` equals `op_a` each time, confirming bit order and 1-cycle sampling alignment.
